// File: rtl/b06_pkg.sv
// ----------------------------------------------------------------------------
// b06_pkg
// Shared definitions for the b06 counter/comparator block and the b06
// interrupt-handler FSM bench.
//
// Contents:
//   cnt_state_t  : counter sequencing states (IDLE, RUN, DONE)
//   CC_*         : encodings of the cc_mux comparison-reference select
//   USC_*        : encodings of the FSM exit code (uscite)
//   cc_is_valid  : helper that tells whether a select value names a reference
// ----------------------------------------------------------------------------
package b06_pkg;

    // Counter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_t;

    // Comparison-reference select values driven by the FSM on cc_mux.
    localparam logic [1:0] CC_REF0 = 2'b00;
    localparam logic [1:0] CC_REFA = 2'b01;
    localparam logic [1:0] CC_REFB = 2'b10;
    localparam logic [1:0] CC_CNT  = 2'b11;

    // Exit codes the FSM reports on uscite when it acknowledges.
    localparam logic [1:0] USC_NONE  = 2'b00;
    localparam logic [1:0] USC_CODE1 = 2'b01;
    localparam logic [1:0] USC_CODE2 = 2'b10;
    localparam logic [1:0] USC_CODE3 = 2'b11;

    // Every 2-bit select value maps to a reference; kept as a helper so the
    // FSM bench can assert on its own cc_mux drive without hard-coding that.
    function automatic logic cc_is_valid(input logic [1:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            CC_REF0, CC_REFA, CC_REFB, CC_CNT: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : b06_pkg

// File: rtl/b06_edge_det.sv
// ----------------------------------------------------------------------------
// b06_edge_det
// One-bit rising-edge detector with synchronous active-high reset.
//
// Ports:
//   clock    in   sole clock, rising edge active
//   reset    in   synchronous active-high reset, clears history and pulse
//   i_sig    in   level to watch
//   o_rise   out  combinational: i_sig high now while history says low
//   o_pulse  out  registered one-cycle pulse following each rising edge
// ----------------------------------------------------------------------------
module b06_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    // The edge is judged against the registered history, so a level held
    // high only produces a single edge no matter how long it stays up.
    assign o_rise = i_sig & ~r_prev;

    // History and pulse are both cleared by reset. Clearing the history
    // means a level that is already high when reset is released counts as a
    // fresh edge on the first free-running cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_pulse <= o_rise;
        end
    end

    assign o_pulse = r_pulse;

endmodule : b06_edge_det

// File: rtl/b06_count_cmp.sv
// ----------------------------------------------------------------------------
// b06_count_cmp
// Counter/comparator companion to the b06 interrupt-handler FSM. Counts
// enabled cycles up to a terminal count, compares data_in against a selected
// reference, and latches the FSM exit code on each acknowledge edge.
//
// Parameters:
//   WIDTH  counter and data width
//   TERM   terminal count, 2 .. 2**WIDTH-1
//   REF0   constant reference used for cc_mux = CC_REF0
//
// Ports:
//   clock         in   sole clock, rising edge active
//   reset         in   synchronous active-high reset, dominates all inputs
//   enable_count  in   count enable from the FSM
//   ackout        in   acknowledge level from the FSM
//   cc_mux        in   comparison-reference select
//   uscite        in   FSM exit code
//   data_in       in   compared value and reference load value
//   load_a        in   load ref_a from data_in
//   load_b        in   load ref_b from data_in
//   cont_eql      out  terminal count reached
//   eql           out  registered data_in == selected reference
//   count         out  current count
//   code_out      out  uscite captured at the last ackout rising edge
//   ack_evt       out  one-cycle pulse per ackout rising edge
//
// Build option:
//   B06_CNT_AUTOCLR_EN  when defined, DONE lasts one cycle and the block
//                       returns to IDLE with count 0 regardless of enable,
//                       making cont_eql a single-cycle pulse. When undefined,
//                       DONE holds count at TERM until enable_count drops.
// ----------------------------------------------------------------------------
module b06_count_cmp
    import b06_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TERM  = 10,
    parameter int unsigned REF0  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_count,
    input  logic             ackout,
    input  logic [1:0]       cc_mux,
    input  logic [1:0]       uscite,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    output logic             cont_eql,
    output logic             eql,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       code_out,
    output logic             ack_evt
);

    localparam logic [WIDTH-1:0] TERM_V    = WIDTH'(TERM);
    localparam logic [WIDTH-1:0] TERM_M1_V = WIDTH'(TERM - 1);
    localparam logic [WIDTH-1:0] REF0_V    = WIDTH'(REF0);
    localparam logic [WIDTH-1:0] ONE_V     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V    = '0;

    cnt_state_t       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_cont_eql;
    logic             r_eql;
    logic [WIDTH-1:0] r_ref_a;
    logic [WIDTH-1:0] r_ref_b;
    logic [1:0]       r_code;
    logic [WIDTH-1:0] w_ref;
    logic             w_ack_rise;
    logic             w_ack_pulse;

    // Counter sequencing. IDLE waits for enable and starts the count at 1,
    // RUN advances on enabled cycles and pauses otherwise, and DONE marks
    // the terminal count. The increment and the terminal test both use the
    // count as it stands this cycle, so cont_eql rises on the same edge the
    // count becomes TERM and the count can never pass TERM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= ZERO_V;
            r_cont_eql <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable_count) begin
                        r_count <= ONE_V;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (enable_count) begin
                        r_count <= r_count + ONE_V;
                        if (r_count == TERM_M1_V) begin
                            r_cont_eql <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
`ifdef B06_CNT_AUTOCLR_EN
                    r_count    <= ZERO_V;
                    r_cont_eql <= 1'b0;
                    r_state    <= IDLE;
`else
                    if (!enable_count) begin
                        r_count    <= ZERO_V;
                        r_cont_eql <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_count    <= TERM_V;
                        r_cont_eql <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state    <= IDLE;
                    r_count    <= ZERO_V;
                    r_cont_eql <= 1'b0;
                end
            endcase
        end
    end

    // Reference select. Everything here reads register outputs, so the
    // compare always sees the references and count from before this edge.
    always_comb begin
        w_ref = REF0_V;
        case (cc_mux)
            CC_REF0: w_ref = REF0_V;
            CC_REFA: w_ref = r_ref_a;
            CC_REFB: w_ref = r_ref_b;
            CC_CNT:  w_ref = r_count;
            default: w_ref = REF0_V;
        endcase
    end

    // Registered comparator and the two loadable references. A load and a
    // compare in the same cycle naturally compare against the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_eql   <= 1'b0;
            r_ref_a <= ZERO_V;
            r_ref_b <= ZERO_V;
        end else begin
            r_eql <= (data_in == w_ref);
            if (load_a) begin
                r_ref_a <= data_in;
            end
            if (load_b) begin
                r_ref_b <= data_in;
            end
        end
    end

    // Acknowledge edge detection; its pulse register is the ack_evt output.
    b06_edge_det u_ack_edge (
        .clock   (clock),
        .reset   (reset),
        .i_sig   (ackout),
        .o_rise  (w_ack_rise),
        .o_pulse (w_ack_pulse)
    );

    // Exit-code capture on each acknowledge edge. Reset wins over an edge
    // arriving in the same cycle, so that edge is simply lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_code <= USC_NONE;
        end else if (w_ack_rise) begin
            r_code <= uscite;
        end
    end

    assign cont_eql = r_cont_eql;
    assign eql      = r_eql;
    assign count    = r_count;
    assign code_out = r_code;
    assign ack_evt  = w_ack_pulse;

endmodule : b06_count_cmp

// File: tb/tb_b06_count_cmp.sv
// ----------------------------------------------------------------------------
// tb_b06_count_cmp
// Self-checking bench for b06_count_cmp. A cycle-level model derived from
// the block's rules runs alongside the DUT and is compared every cycle;
// directed sequences also pin hand-computed values.
// Honours B06_CNT_AUTOCLR_EN so it matches the RTL build it is paired with.
// ----------------------------------------------------------------------------
module tb_b06_count_cmp;

    localparam int WIDTH = 4;
    localparam int TERM  = 10;
    localparam int REF0  = 0;
`ifdef B06_CNT_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             enable_count;
    logic             ackout;
    logic [1:0]       cc_mux;
    logic [1:0]       uscite;
    logic [WIDTH-1:0] data_in;
    logic             load_a;
    logic             load_b;
    logic             cont_eql;
    logic             eql;
    logic [WIDTH-1:0] count;
    logic [1:0]       code_out;
    logic             ack_evt;

    int nCompared;
    int nMismatched;
    bit checkOn;

    // Model state: plain integers and flags, no notion of FSM states.
    int               mCount;
    logic             mCont;
    logic             mEql;
    logic             mAck;
    logic             mPrev;
    logic [1:0]       mCode;
    logic [WIDTH-1:0] mRefA;
    logic [WIDTH-1:0] mRefB;

    b06_count_cmp #(
        .WIDTH (WIDTH),
        .TERM  (TERM),
        .REF0  (REF0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_count (enable_count),
        .ackout       (ackout),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .data_in      (data_in),
        .load_a       (load_a),
        .load_b       (load_b),
        .cont_eql     (cont_eql),
        .eql          (eql),
        .count        (count),
        .code_out     (code_out),
        .ack_evt      (ack_evt)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Runaway guard.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model, advanced on each rising edge from the rules: the count
    // is the number of enabled edges since the last clear, pinned at TERM,
    // and cleared once it has sat at TERM and enable is low (or always, with
    // auto-clear). The comparator sees the count from before the edge.
    always @(posedge clock) begin
        logic [WIDTH-1:0] refv;
        if (reset) begin
            mCount = 0;
            mCont  = 1'b0;
            mEql   = 1'b0;
            mAck   = 1'b0;
            mPrev  = 1'b0;
            mCode  = 2'b00;
            mRefA  = '0;
            mRefB  = '0;
        end else begin
            case (cc_mux)
                2'd0:    refv = WIDTH'(REF0);
                2'd1:    refv = mRefA;
                2'd2:    refv = mRefB;
                default: refv = WIDTH'(mCount);
            endcase
            mEql = (data_in == refv);
            if (load_a) mRefA = data_in;
            if (load_b) mRefB = data_in;
            if (mCount == TERM) begin
                mCount = (AUTOCLR || !enable_count) ? 0 : TERM;
            end else if (enable_count) begin
                mCount = mCount + 1;
            end
            mCont = (mCount == TERM);
            mAck  = ackout && !mPrev;
            if (mAck) mCode = uscite;
            mPrev = ackout;
        end
    end

    // One comparison: X/Z on the DUT side also counts as a mismatch.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        checkVal("model_count",    32'(count),    32'(mCount));
        checkVal("model_cont_eql", 32'(cont_eql), 32'(mCont));
        checkVal("model_eql",      32'(eql),      32'(mEql));
        checkVal("model_code_out", 32'(code_out), 32'(mCode));
        checkVal("model_ack_evt",  32'(ack_evt),  32'(mAck));
    endtask

    // Outputs are sampled on the falling edge, well clear of the active edge.
    always @(negedge clock) begin
        if (checkOn) checkOutput();
    end

    // Drive one cycle of inputs, then wait until the resulting edge has
    // settled (next falling edge).
    task automatic applyStimulus(input logic rst, input logic en, input logic ack,
                                 input logic [1:0] cc, input logic [1:0] usc,
                                 input logic [WIDTH-1:0] din,
                                 input logic la, input logic lb);
        reset        = rst;
        enable_count = en;
        ackout       = ack;
        cc_mux       = cc;
        uscite       = usc;
        data_in      = din;
        load_a       = la;
        load_b       = lb;
        @(negedge clock);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        checkOn     = 1'b0;
        reset = 1'b1; enable_count = 1'b0; ackout = 1'b0; cc_mux = 2'b00;
        uscite = 2'b00; data_in = '0; load_a = 1'b0; load_b = 1'b0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                          4'($urandom), 1'($urandom), 1'($urandom));
            checkOn = 1'b1;
        end
        checkVal("rst_count",    32'(count),    32'd0);
        checkVal("rst_cont_eql", 32'(cont_eql), 32'd0);
        checkVal("rst_eql",      32'(eql),      32'd0);
        checkVal("rst_code_out", 32'(code_out), 32'd0);
        checkVal("rst_ack_evt",  32'(ack_evt),  32'd0);

        // Full count with continuous enable.
        for (int i = 1; i <= TERM; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
            checkVal("full_count", 32'(count), 32'(i));
            checkVal("full_cont_eql", 32'(cont_eql), (i == TERM) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("term_hold_count",    32'(count),    AUTOCLR ? 32'd0 : 32'd10);
        checkVal("term_hold_cont_eql", 32'(cont_eql), AUTOCLR ? 32'd0 : 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("term_drop_count",    32'(count),    32'd0);
        checkVal("term_drop_cont_eql", 32'(cont_eql), 32'd0);

        // Pause: 3 enabled, 2 paused, then re-enabled.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("pause_pre", 32'(count), 32'd3);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
            checkVal("pause_hold", 32'(count), 32'd3);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("pause_resume", 32'(count), 32'd4);

        // Reset mid-count at 6, enable kept high across it.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("mid_pre_count", 32'(count), 32'd6);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("mid_rst_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("mid_restart_count", 32'(count), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);

        // Comparator and reference loads.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd5, 1'b1, 1'b0);
        checkVal("cmp_load_a_ref0", 32'(eql), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd5, 1'b0, 1'b0);
        checkVal("cmp_refa_5", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd6, 1'b0, 1'b0);
        checkVal("cmp_refa_6", 32'(eql), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("cmp_ref0_0", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd7, 1'b1, 1'b0);
        checkVal("cmp_load_same_cycle", 32'(eql), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd7, 1'b0, 1'b0);
        checkVal("cmp_refa_7", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'd9, 1'b1, 1'b1);
        checkVal("cmp_load_both_old_b", 32'(eql), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'd9, 1'b0, 1'b0);
        checkVal("cmp_refb_9", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd9, 1'b0, 1'b0);
        checkVal("cmp_refa_9", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("cmp_cnt_pre0", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 4'd1, 1'b0, 1'b0);
        checkVal("cmp_cnt_pre1", 32'(eql), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 4'd3, 1'b0, 1'b0);
        checkVal("cmp_cnt_pre2_vs3", 32'(eql), 32'd0);

        // Acknowledge capture and hold-high suppression.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        checkVal("ack_idle_evt", 32'(ack_evt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 4'd0, 1'b0, 1'b0);
        checkVal("ack_rise_evt",  32'(ack_evt),  32'd1);
        checkVal("ack_rise_code", 32'(code_out), 32'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'd0, 1'b0, 1'b0);
            checkVal("ack_held_evt",  32'(ack_evt),  32'd0);
            checkVal("ack_held_code", 32'(code_out), 32'd3);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 4'd0, 1'b0, 1'b0);
        checkVal("ack_rise2_code", 32'(code_out), 32'd2);

        // Edge coinciding with reset is lost; cleared history re-arms it.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 4'd0, 1'b0, 1'b0);
        checkVal("ack_rst_evt",  32'(ack_evt),  32'd0);
        checkVal("ack_rst_code", 32'(code_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 4'd0, 1'b0, 1'b0);
        checkVal("ack_post_rst_evt",  32'(ack_evt),  32'd1);
        checkVal("ack_post_rst_code", 32'(code_out), 32'd1);

        // A pending event is cleared by reset.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 4'd0, 1'b0, 1'b0);
        checkVal("ack_pend_evt", 32'(ack_evt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 4'd0, 1'b0, 1'b0);
        checkVal("ack_pend_rst_evt", 32'(ack_evt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0);

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_b06_count_cmp
